cordic_vectoring: RTL and testbench

Iterative CORDIC engine in vectoring mode, the inverse of the rotation-mode shift-accumulate stages. Takes a signed Cartesian vector (x, y) and drives y toward zero with one micro-rotation per clock. Returns the uncompensated magnitude and the angle in binary angle units. Feeds phase and magnitude detection downstream of the rotation datapath; a start/busy/done handshake sequences it.

---
 rtl/cordic_vectoring.sv | 204 ++++++++++++++++++++
 tb/tb_cordic_vectoring.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC engine, vectoring mode.
// Drives y toward zero with one micro-rotation per clock and returns the
// uncompensated magnitude (K * |v|) and the angle in binary angle units
// (2^WIDTH = 360 degrees).
//
// Handshake: start is sampled only in IDLE; the cycle it is seen high the
// inputs are captured and busy rises. busy stays high for ITER cycles, then
// done pulses for exactly one cycle with mag_out/angle_out valid. busy and
// done are never high together. start in RUN or DONE is ignored, and the
// results hold until the next done.
module cordic_vectoring #(
   parameter int WIDTH = 32,
   parameter int ITER  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH+1:0] mag_out,
   output logic        [WIDTH-1:0] angle_out
);

   // Two guard bits cover K*sqrt(2)*2^(WIDTH-1) and the negation of the most
   // negative input.
   localparam int XW = WIDTH + 2;
   localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [IW-1:0]    LAST        = IW'(ITER - 1);
   localparam logic [WIDTH-1:0] QUARTER     = {2'b01, {(WIDTH-2){1'b0}}};
   localparam logic [WIDTH-1:0] NEG_QUARTER = {2'b11, {(WIDTH-2){1'b0}}};

   // Elaboration-time arctangent: round(atan(2^-idx) * 2^WIDTH / (2*pi)).
   // atan(1) is taken as pi/4; smaller arguments use the Taylor series,
   // which converges at least as fast as 0.25^k for idx >= 1.
   function automatic logic [WIDTH-1:0] atan_const(input int idx);
      real pi;
      real arg;
      real arg2;
      real term;
      real sum;
      real scaled;
      longint rounded;
      pi  = 3.14159265358979323846;
      arg = 1.0;
      for (int k = 0; k < idx; k++) begin
         arg = arg / 2.0;
      end
      if (idx == 0) begin
         sum = pi / 4.0;
      end else begin
         arg2 = arg * arg;
         term = arg;
         sum  = 0.0;
         for (int k = 0; k < 40; k++) begin
            sum  = sum + term / real'(2 * k + 1);
            term = -term * arg2;
         end
      end
      scaled = sum / (2.0 * pi);
      for (int k = 0; k < WIDTH; k++) begin
         scaled = scaled * 2.0;
      end
      rounded = longint'(scaled);
      return WIDTH'(rounded);
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic signed [XW-1:0]  x_r;
   logic signed [XW-1:0]  y_r;
   logic        [WIDTH-1:0] z_r;
   logic        [IW-1:0]  i_r;
   logic                  zero_flag;

   logic signed [XW-1:0]  x_ext;
   logic signed [XW-1:0]  y_ext;
   logic signed [XW-1:0]  x_init;
   logic signed [XW-1:0]  y_init;
   logic        [WIDTH-1:0] z_init;

   logic signed [XW-1:0]  x_shift;
   logic signed [XW-1:0]  y_shift;
   logic signed [XW-1:0]  x_nx;
   logic signed [XW-1:0]  y_nx;
   logic        [WIDTH-1:0] z_nx;

   logic        [WIDTH-1:0] atan_tab [ITER];

   for (genvar g = 0; g < ITER; g++) begin : g_atan
      localparam logic [WIDTH-1:0] ATAN_G = atan_const(g);
      assign atan_tab[g] = ATAN_G;
   end

   assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
   assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: one pass through RUN lasts exactly ITER cycles.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (i_r == LAST) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Quadrant pre-rotation so the iterations start from the right half-plane.
   always_comb begin
      x_init = x_ext;
      y_init = y_ext;
      z_init = '0;
      if (x_in[WIDTH-1]) begin
         if (!y_in[WIDTH-1]) begin
            x_init = y_ext;
            y_init = -x_ext;
            z_init = QUARTER;
         end else begin
            x_init = -y_ext;
            y_init = x_ext;
            z_init = NEG_QUARTER;
         end
      end
   end

   // One micro-rotation: rotate against the sign of y to drive it to zero.
   always_comb begin
      x_shift = x_r >>> i_r;
      y_shift = y_r >>> i_r;
      if (!y_r[XW-1]) begin
         x_nx = x_r + y_shift;
         y_nx = y_r - x_shift;
         z_nx = z_r + atan_tab[i_r];
      end else begin
         x_nx = x_r - y_shift;
         y_nx = y_r + x_shift;
         z_nx = z_r - atan_tab[i_r];
      end
   end

   // Datapath: capture in IDLE, iterate in RUN, load results on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         i_r       <= '0;
         zero_flag <= 1'b0;
         mag_out   <= '0;
         angle_out <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            x_r       <= x_init;
            y_r       <= y_init;
            z_r       <= z_init;
            i_r       <= '0;
            zero_flag <= (x_in == '0) && (y_in == '0);
         end else if (state == S_RUN) begin
            x_r <= x_nx;
            y_r <= y_nx;
            z_r <= z_nx;
            i_r <= i_r + 1'b1;
            if (i_r == LAST) begin
               // A zero vector has no defined angle; report it as all zeros.
               mag_out   <= zero_flag ? '0 : x_nx;
               angle_out <= zero_flag ? '0 : z_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: real-valued reference model feeding an
// expected-result scoreboard, per-scenario tasks, one summary line.
module tb_cordic_vectoring;

   localparam int WIDTH = 32;
   localparam int ITER  = 16;

   logic                    clk;
   logic                    rst_n;
   logic                    start;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic                    busy;
   logic                    done;
   logic signed [WIDTH+1:0] mag_out;
   logic        [WIDTH-1:0] angle_out;

   int checks;
   int failures;

   logic [WIDTH+1:0] exp_mag_q [$];
   logic [WIDTH-1:0] exp_ang_q [$];
   bit               exp_exact_q [$];

   cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .mag_out   (mag_out),
      .angle_out (angle_out)
   );

   // Clock and reset defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: K*|v| and atan2 scaled to 2^WIDTH per turn.
   function automatic void model(input int xv, input int yv,
                                 output logic [WIDTH+1:0] m,
                                 output logic [WIDTH-1:0] a);
      real k;
      real pi;
      real mr;
      real ar;
      pi = 3.14159265358979323846;
      k  = 1.0;
      for (int i = 0; i < ITER; i++) begin
         k = k * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
      end
      mr = k * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      ar = $atan2(real'(yv), real'(xv)) / (2.0 * pi) * 4294967296.0;
      m  = (WIDTH+2)'(longint'(mr));
      a  = WIDTH'(longint'(ar));
   endfunction

   task automatic push_expected(input int xv, input int yv);
      logic [WIDTH+1:0] m;
      logic [WIDTH-1:0] a;
      model(xv, yv, m, a);
      exp_mag_q.push_back(m);
      exp_ang_q.push_back(a);
      exp_exact_q.push_back((xv == 0) && (yv == 0));
   endtask

   // Pop one expectation and compare against the current outputs.
   task automatic score_result(input string name);
      logic [WIDTH+1:0]        e_mag;
      logic [WIDTH-1:0]        e_ang;
      bit                      exact;
      logic signed [WIDTH-1:0] d_ang;
      longint                  d_mag;
      longint                  tol;
      if (exp_mag_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_queue: got result with empty expected queue", name);
         return;
      end
      e_mag = exp_mag_q.pop_front();
      e_ang = exp_ang_q.pop_front();
      exact = exp_exact_q.pop_front();
      if (exact) begin
         checks++;
         if (mag_out !== '0) begin
            failures++;
            $display("FAIL %s_mag_zero: got %0h expected 0", name, mag_out);
         end
         checks++;
         if (angle_out !== '0) begin
            failures++;
            $display("FAIL %s_ang_zero: got %0h expected 0", name, angle_out);
         end
      end else begin
         d_mag = longint'(mag_out) - longint'($signed(e_mag));
         if (d_mag < 0) d_mag = -d_mag;
         tol = longint'(real'(e_mag) / 16384.0) + 64;
         checks++;
         if (d_mag > tol || $isunknown(mag_out) || mag_out[WIDTH+1]) begin
            failures++;
            $display("FAIL %s_mag: got %0h expected %0h (tol %0d)", name, mag_out, e_mag, tol);
         end
         d_ang = angle_out - e_ang;
         checks++;
         if (d_ang > 32'sd131072 || d_ang < -32'sd131072 || $isunknown(angle_out)) begin
            failures++;
            $display("FAIL %s_ang: got %0h expected %0h", name, angle_out, e_ang);
         end
      end
   endtask

   // Full transaction: inputs are scrambled right after capture.
   task automatic run_vector(input string name, input int xv, input int yv);
      int idx;
      push_expected(xv, yv);
      @(negedge clk);
      start = 1'b1;
      x_in  = xv;
      y_in  = yv;
      @(posedge clk);
      #1;
      start = 1'b0;
      x_in  = $urandom;
      y_in  = $urandom;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy_e0: got busy=%b done=%b expected busy=1 done=0", name, busy, done);
      end
      idx = 0;
      while (done !== 1'b1 && idx < 40) begin
         @(negedge clk);
         idx++;
         x_in = $urandom;
         y_in = $urandom;
         if (busy === 1'b1 && done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_busy_done: busy and done both high at cycle %0d", name, idx);
         end
      end
      checks++;
      if (done !== 1'b1 || idx != ITER) begin
         failures++;
         $display("FAIL %s_latency: got done=%b at cycle %0d expected done=1 at %0d", name, done, idx, ITER);
      end
      score_result(name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse: got busy=%b done=%b expected 0/0", name, busy, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      x_in  = '0;
      y_in  = '0;
      #3;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++;
      if (mag_out !== '0) begin failures++; $display("FAIL reset_mag: got %0h expected 0", mag_out); end
      checks++;
      if (angle_out !== '0) begin failures++; $display("FAIL reset_ang: got %0h expected 0", angle_out); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_vectors();
      run_vector("pos_x",    1000000,        0);
      run_vector("diag_q1",  1000000,  1000000);
      run_vector("diag_q3", -1000000, -1000000);
      run_vector("neg_x",   -1000000,        0);
      run_vector("neg_y",          0, -1000000);
      run_vector("diag_q2", -700000,    400000);
   endtask

   task automatic test_boundaries();
      run_vector("zero", 0, 0);
      run_vector("min_min", 32'sh8000_0000, 32'sh8000_0000);
      run_vector("max_pos", 32'sh7fff_ffff, 32'sh7fff_ffff);
   endtask

   task automatic test_random();
      int xv;
      int yv;
      for (int n = 0; n < 6; n++) begin
         xv = int'($urandom_range(500000, 1500000));
         yv = int'($urandom_range(500000, 1500000));
         if ($urandom_range(0, 1) == 1) xv = -xv;
         if ($urandom_range(0, 1) == 1) yv = -yv;
         run_vector("random", xv, yv);
      end
   endtask

   // start held high for 40 edges: captures at E0, E18, E36 only.
   task automatic test_back_to_back();
      int done_edges [$];
      push_expected(1200000, -300000);
      push_expected(-50000, 900000);
      push_expected(400000, 400000);
      @(negedge clk);
      start = 1'b1;
      x_in  = 1200000;
      y_in  = -300000;
      for (int e = 0; e < 58; e++) begin
         @(negedge clk);
         if (busy === 1'b1 && done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL b2b_busy_done: both high after edge %0d", e);
         end
         if (done === 1'b1) begin
            done_edges.push_back(e);
            score_result("b2b");
         end
         if (e == 10) begin x_in = -50000; y_in = 900000; end
         if (e == 28) begin x_in = 400000; y_in = 400000; end
         if (e == 39) start = 1'b0;
      end
      checks++;
      if (done_edges.size() != 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d done pulses expected 3", done_edges.size());
      end else begin
         checks++;
         if (done_edges[0] != 16 || done_edges[1] != 34 || done_edges[2] != 52) begin
            failures++;
            $display("FAIL b2b_edges: got %0d,%0d,%0d expected 16,34,52",
                     done_edges[0], done_edges[1], done_edges[2]);
         end
      end
      while (exp_mag_q.size() > 0) begin
         void'(exp_mag_q.pop_front());
         void'(exp_ang_q.pop_front());
         void'(exp_exact_q.pop_front());
      end
   endtask

   // Reset during RUN: outputs clear at once and no done appears.
   task automatic test_reset_abort();
      @(negedge clk);
      start = 1'b1;
      x_in  = 800000;
      y_in  = 600000;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mag_out !== '0 || angle_out !== '0) begin
         failures++;
         $display("FAIL abort_clear: got busy=%b done=%b mag=%0h ang=%0h expected all 0",
                  busy, done, mag_out, angle_out);
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n == 3) rst_n = 1'b1;
         if (done !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL abort_no_done: got done=1 at cycle %0d expected 0", n);
         end
      end
      checks++;
      if (mag_out !== '0 || angle_out !== '0) begin
         failures++;
         $display("FAIL abort_hold: got mag=%0h ang=%0h expected 0", mag_out, angle_out);
      end
      run_vector("after_abort", 300000, -900000);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_vectors();
      test_boundaries();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
